id_ex_pipe_reg: RTL
===================

// Module: id_ex_pipe_reg
// PURPOSE
//  Producer side of the ID->EX message bus: registers the packed {ctrl,data} message from the IDU
//  and presents it to the EXU under a valid/ready handshake. Two-entry skid buffer, so in_ready is
//  a registered signal with no combinational path from out_ready. Synchronous flush for redirects.
//  Invalid/flushed slots present an all-zero message: inst==0 is the EXU's bubble encoding.
// PARAMETERS
//  MSG_WIDTH  185  width of ID_EX_message (20 ctrl + 165 data), equals `ID_EX_WIDTH
//  INST_W     32   width of inst field at message[INST_W-1:0]; pc sits at [2*INST_W-1:INST_W]
// PORTS
//  clk             in   1          single clock, rising edge
//  rst             in   1          asynchronous, active-high reset
//  flush           in   1          drop all buffered entries; sampled at posedge
//  in_valid        in   1          IDU presents a message
//  in_ready        out  1          buffer can accept (registered)
//  in_msg          in   MSG_WIDTH  message from IDU
//  out_valid       out  1          message to EXU is valid
//  out_ready       in   1          EXU consumes message this cycle
//  ID_EX_message   out  MSG_WIDTH  message to EXU; all-zero when out_valid==0
//  debug_pc        out  INST_W     pc field of ID_EX_message (0 when empty)
// BEHAVIOUR
//  - Reset (async): state EMPTY, out_valid=0, in_ready=1, ID_EX_message=0, skid cleared.
//  - Transfer in = in_valid&in_ready; transfer out = out_valid&out_ready; both at posedge.
//  - Entries: MAIN (drives output), SKID (overflow). States EMPTY / ONE / TWO.
//  - EMPTY: in-> ONE (MAIN<=in_msg). Latency in-to-out exactly 1 cycle.
//  - ONE: in&out -> ONE (MAIN<=in_msg); in only -> TWO (SKID<=in_msg); out only -> EMPTY.
//  - TWO: in_ready=0; out -> ONE (MAIN<=SKID); else hold. in_valid ignored.
//  - in_ready = (state!=TWO), registered; out_valid = (state!=EMPTY).
//  - Order strictly FIFO; no message duplicated or lost except by flush.
//  - Output held stable while out_valid&!out_ready.
//  - flush: next state EMPTY, MAIN/SKID zeroed; beats accepted or consumed in the flush cycle are
//    discarded from the buffer; flush wins over every simultaneous event; in_ready=1 next cycle.
//  - ID_EX_message driven from MAIN only when out_valid, else 0 (AND-gated, no X).
//  - in_msg with inst==0 is carried as an ordinary valid entry; no special case.
//  - Reset mid-transfer: all entries lost; no output toggles until a new in transfer.
// CONFIGURATION
//  ID_EX_PERF_EN defined: adds ports perf_stall_cnt out 32 (cycles with out_valid&!out_ready),
//    perf_flush_cnt out 32 (cycles with flush=1 and state!=EMPTY); reset to 0, wrap mod 2^32.
//  ID_EX_PERF_EN undefined: ports and counters absent; all other behaviour bit-identical.
// TESTING
//  1 reset: rst=1 mid-cycle -> out_valid=0, in_ready=1, ID_EX_message=0 immediately (async).
//  2 stream: in_valid=1, out_ready=1, msgs inst=1..8 -> out inst=1..8 one per cycle, 1-cycle lag.
//  3 backpressure: out_ready=0, send A,B -> in_ready=0 after B; C held; out_ready=1 -> A,B,C in order.
//  4 flush in TWO with in_valid=1 -> next cycle out_valid=0, msg=0, in_ready=1; A,B,C never appear.
//  5 flush simultaneous with out transfer in ONE -> state EMPTY, no repeat of consumed message.
//  6 PERF_EN: out_ready=0 for 5 cycles with valid, then 1 flush -> perf_stall_cnt=5, perf_flush_cnt=1.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register: two-entry skid buffer with registered in_ready and synchronous flush.
// Optional performance counters are enabled by defining ID_EX_PERF_EN.
module id_ex_pipe_reg #(
  parameter int MSG_WIDTH = 185,
  parameter int INST_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MSG_WIDTH-1:0] in_msg,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [MSG_WIDTH-1:0] ID_EX_message,
`ifdef ID_EX_PERF_EN
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_flush_cnt,
`endif
  output logic [INST_W-1:0]    debug_pc
);

  // Handshake: a beat moves when valid and ready are both high at posedge; valid never waits on ready.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [MSG_WIDTH-1:0] main_q, main_d;
  logic [MSG_WIDTH-1:0] skid_q, skid_d;
  logic                 in_ready_q, in_ready_d;
  logic                 in_fire, out_fire;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = in_ready_q;
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = ONE;
          main_d  = in_msg;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_msg;
        end else if (in_fire) begin
          state_d = TWO;
          skid_d  = in_msg;
        end else if (out_fire) begin
          state_d = EMPTY;
          main_d  = '0;
        end
      end
      TWO: begin
        // in_ready is low here, so only the drain path exists
        if (out_fire) begin
          state_d = ONE;
          main_d  = skid_q;
          skid_d  = '0;
        end
      end
      default: begin
        state_d = EMPTY;
        main_d  = '0;
        skid_d  = '0;
      end
    endcase
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign ID_EX_message = main_q & {MSG_WIDTH{out_valid}};
  assign debug_pc      = ID_EX_message[2*INST_W-1:INST_W];

`ifdef ID_EX_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid && !out_ready) stall_cnt_d = stall_cnt_q + 32'd1;
    if (flush && (state_q != EMPTY)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule
